ibusif_prefetch: RTL

//  Instruction-fetch bus master between the pipeline fetch stage and the AHB-lite-like ibus.

---
 rtl/ibusif_prefetch.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/ibusif_prefetch.sv
// Sequential instruction prefetcher on a pipelined ibus, feeding a halfword queue.
// Handles redirects during stalls (pending jump, stale response drop) and fault tagging.
module ibusif_prefetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          IFQ_DEPTH = 4,
  parameter int          LVL_W     = $clog2(IFQ_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             jmp_req,
  input  logic [31:0]      jmp_addr,
  input  logic             instr_fetch,
  input  logic             instr_fetch_16bit,
  output logic [1:0]       instr_vld_size,
  output logic [31:0]      instr,
  output logic             instr_has_fault,
  output logic [LVL_W-1:0] ifq_level,
  output logic [31:0]      haddr,
  output logic [1:0]       hsize,
  output logic             htrans,
  output logic             hprot,
  output logic             hwrite,
  output logic [31:0]      hwdata,
  input  logic [31:0]      hrdata,
  input  logic             hresp,
  input  logic             hready
);

  localparam int IDX_W = $clog2(IFQ_DEPTH);
  localparam int CNT_W = LVL_W + 2;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(IFQ_DEPTH);
  localparam logic [IDX_W:0]   DEPTH_I = (IDX_W + 1)'(IFQ_DEPTH);

  logic [15:0]          hw_q [IFQ_DEPTH];
  logic [15:0]          hw_d [IFQ_DEPTH];
  logic [IFQ_DEPTH-1:0] ft_q, ft_d;
  logic [IDX_W-1:0]     rd_q, rd_d, wr_q, wr_d;
  logic [LVL_W-1:0]     lvl_q, lvl_d;
  logic [31:0]          haddr_q, haddr_d;
  logic [31:0]          tgt_q, tgt_d;
  logic                 dph_vld_q, dph_vld_d;
  logic                 dph_a1_q, dph_a1_d;
  logic                 dph_stale_q, dph_stale_d;
  logic                 fault_q, fault_d;
  logic                 pend_q, pend_d;
  logic                 first_q, first_d;

  logic                 stalled_s, push_s, fault_s, accept_s, htrans_s;
  logic [31:0]          haddr_s;
  logic [1:0]           push_n_s, push_cnt_s, pop_n_s, infl_s, need_s;
  logic [CNT_W-1:0]     free_s;
  logic [IDX_W-1:0]     wr1_s, rd1_s;
  logic                 unused_s;

  function automatic logic [IDX_W-1:0] idx_add(input logic [IDX_W-1:0] p, input logic [1:0] n);
    logic [IDX_W:0] s;
    s = {1'b0, p} + (IDX_W + 1)'(n);
    if (s >= DEPTH_I) begin
      s = s - DEPTH_I;
    end else begin
      s = s;
    end
    return s[IDX_W-1:0];
  endfunction

  assign unused_s = jmp_addr[0];

  // Bus control: stall detection, redirect selection, free-space issue rule.
  always_comb begin
    stalled_s = dph_vld_q & ~hready;
    push_s    = dph_vld_q & hready & ~dph_stale_q & ~jmp_req;
    push_n_s  = dph_a1_q ? 2'd1 : 2'd2;
    push_cnt_s = push_s ? push_n_s : 2'd0;
    infl_s    = (dph_vld_q & ~dph_stale_q) ? push_n_s : 2'd0;
    if (instr_fetch & ~jmp_req) begin
      pop_n_s = instr_fetch_16bit ? 2'd1 : 2'd2;
    end else begin
      pop_n_s = 2'd0;
    end
    if (stalled_s) begin
      haddr_s = haddr_q;
    end else if (jmp_req) begin
      haddr_s = {jmp_addr[31:1], 1'b0};
    end else if (pend_q) begin
      haddr_s = tgt_q;
    end else begin
      haddr_s = haddr_q;
    end
    // A faulting beat completing now already blocks the next issue.
    fault_s = (fault_q | (push_s & hresp)) & ~jmp_req;
    need_s  = haddr_s[1] ? 2'd1 : 2'd2;
    if (jmp_req) begin
      free_s = DEPTH_C;
    end else begin
      free_s = DEPTH_C - CNT_W'(lvl_q) - CNT_W'(infl_s) + CNT_W'(pop_n_s);
    end
    htrans_s = ~first_q & ~stalled_s & ~fault_s & (free_s >= CNT_W'(need_s));
    accept_s = htrans_s & hready;
  end

  // Next-state for address phase, data phase tracking and pending jump.
  always_comb begin
    first_d = 1'b0;
    fault_d = fault_s;
    haddr_d = accept_s ? {haddr_s[31:2] + 30'd1, 2'b00} : haddr_s;
    if (stalled_s) begin
      dph_vld_d   = dph_vld_q;
      dph_a1_d    = dph_a1_q;
      dph_stale_d = dph_stale_q | jmp_req;
      pend_d      = pend_q | jmp_req;
      tgt_d       = jmp_req ? {jmp_addr[31:1], 1'b0} : tgt_q;
    end else begin
      dph_vld_d   = accept_s;
      dph_a1_d    = haddr_s[1];
      dph_stale_d = 1'b0;
      pend_d      = 1'b0;
      tgt_d       = tgt_q;
    end
  end

  // Queue write/read pointers and level; a jump flushes everything.
  always_comb begin
    hw_d  = hw_q;
    ft_d  = ft_q;
    rd_d  = rd_q;
    wr_d  = wr_q;
    lvl_d = lvl_q;
    wr1_s = idx_add(wr_q, 2'd1);
    if (jmp_req) begin
      rd_d  = '0;
      wr_d  = '0;
      lvl_d = '0;
    end else begin
      if (push_s) begin
        if (dph_a1_q) begin
          hw_d[wr_q] = hrdata[31:16];
          ft_d[wr_q] = hresp;
        end else begin
          hw_d[wr_q]  = hrdata[15:0];
          ft_d[wr_q]  = hresp;
          hw_d[wr1_s] = hrdata[31:16];
          ft_d[wr1_s] = hresp;
        end
        wr_d = idx_add(wr_q, push_n_s);
      end else begin
        wr_d = wr_q;
      end
      rd_d  = idx_add(rd_q, pop_n_s);
      lvl_d = lvl_q + LVL_W'(push_cnt_s) - LVL_W'(pop_n_s);
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < IFQ_DEPTH; i++) begin
        hw_q[i] <= 16'h0000;
      end
      ft_q        <= '0;
      rd_q        <= '0;
      wr_q        <= '0;
      lvl_q       <= '0;
      haddr_q     <= RESET_PC;
      tgt_q       <= 32'h0000_0000;
      dph_vld_q   <= 1'b0;
      dph_a1_q    <= 1'b0;
      dph_stale_q <= 1'b0;
      fault_q     <= 1'b0;
      pend_q      <= 1'b0;
      first_q     <= 1'b1;
    end else begin
      hw_q        <= hw_d;
      ft_q        <= ft_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      lvl_q       <= lvl_d;
      haddr_q     <= haddr_d;
      tgt_q       <= tgt_d;
      dph_vld_q   <= dph_vld_d;
      dph_a1_q    <= dph_a1_d;
      dph_stale_q <= dph_stale_d;
      fault_q     <= fault_d;
      pend_q      <= pend_d;
      first_q     <= first_d;
    end
  end

  // Head view of the queue.
  always_comb begin
    rd1_s = idx_add(rd_q, 2'd1);
    instr = {hw_q[rd1_s], hw_q[rd_q]};
    if (lvl_q == LVL_W'(0)) begin
      instr_vld_size = 2'b00;
    end else if (lvl_q == LVL_W'(1)) begin
      instr_vld_size = 2'b01;
    end else begin
      instr_vld_size = 2'b10;
    end
    instr_has_fault = ((lvl_q != LVL_W'(0)) & ft_q[rd_q]) |
                      ((lvl_q >= LVL_W'(2)) & ft_q[rd1_s]);
  end

  assign ifq_level = lvl_q;
  assign haddr     = haddr_s;
  assign hsize     = haddr_s[1] ? 2'b01 : 2'b10;
  assign htrans    = htrans_s;
  assign hprot     = 1'b0;
  assign hwrite    = 1'b0;
  assign hwdata    = 32'h0000_0000;

endmodule
